// File: rtl/rom_dma_engine_pkg.sv
// Shared definitions for the ROM-to-memory DMA engine and the memory controller decode.
package rom_dma_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Register select values carried on wr_mode
    localparam logic [1:0] MODE_SRC_LO = 2'd0;
    localparam logic [1:0] MODE_SRC_HI = 2'd1;
    localparam logic [1:0] MODE_DST    = 2'd2;
    localparam logic [1:0] MODE_LEN_GO = 2'd3;

    // Base of the DMA register window in the processor data space
    localparam logic [15:0] DMA_BASE = 16'hFF00;

endpackage

// File: rtl/rom_dma_engine.sv
// Copies len 16-bit words from the ROM controller into data memory while the
// processor is stalled. One word at a time: request, guard, wait, write.
module rom_dma_engine
    import rom_dma_engine_pkg::*;
#(
    parameter int SRC_W   = 24,
    parameter int DST_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             write,
    input  logic [1:0]       wr_mode,
    input  logic [15:0]      ctrl_data,
    output logic [SRC_W-1:0] src_addr,
    output logic             load_rom,
    input  logic [15:0]      src_data,
    input  logic             ready,
    output logic [DST_W-1:0] dst_addr,
    output logic             dst_write,
    output logic [15:0]      dst_data,
    output logic             proc_en,
    output logic             busy,
    output logic             error
);

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   src_q;
    logic [DST_W-1:0]   dst_q;
    logic [15:0]        len_q;
    logic [15:0]        buf_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               guard_q;
    logic               error_q;

    logic               cfg_wr;
    logic               start;
    logic               tmo_expire;

    // Register window is only live while idle; the processor is stalled otherwise
    assign cfg_wr     = en && write && (state_q == IDLE);
    assign start      = cfg_wr && (wr_mode == MODE_LEN_GO) && (ctrl_data != 16'd0);
    // Abort on the TIMEOUT-th non-ready cycle after the guard cycle
    assign tmo_expire = (state_q == WAIT) && !guard_q && !ready &&
                        (tmo_q == TMO_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = REQ;
            REQ:   state_d = WAIT;
            WAIT: begin
                if (!guard_q) begin
                    if (ready)           state_d = WRITE;
                    else if (tmo_expire) state_d = IDLE;
                end
            end
            WRITE: state_d = (len_q == 16'd1) ? IDLE : REQ;
            default: state_d = IDLE;
        endcase
    end

    // Configuration registers, address/length counters, timeout and capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            tmo_q   <= '0;
            guard_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_wr) begin
                        case (wr_mode)
                            MODE_SRC_LO: src_q[15:0]       <= ctrl_data;
                            MODE_SRC_HI: src_q[SRC_W-1:16] <= ctrl_data[SRC_W-17:0];
                            MODE_DST:    dst_q             <= DST_W'(ctrl_data);
                            MODE_LEN_GO: begin
                                len_q <= ctrl_data;
                                if (ctrl_data != 16'd0) error_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                REQ: begin
                    tmo_q   <= '0;
                    guard_q <= 1'b1;
                end
                WAIT: begin
                    guard_q <= 1'b0;
                    if (!guard_q) begin
                        if (ready)           buf_q <= src_data;
                        else                 tmo_q <= tmo_q + 1'b1;
                        if (tmo_expire)      error_q <= 1'b1;
                    end
                end
                WRITE: begin
                    src_q <= src_q + 1'b1;
                    dst_q <= dst_q + 1'b1;
                    len_q <= len_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state register; addresses and data come from registers
    assign load_rom  = (state_q == REQ);
    assign dst_write = (state_q == WRITE);
    assign proc_en   = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign error     = error_q;
    assign src_addr  = src_q;
    assign dst_addr  = dst_q;
    assign dst_data  = buf_q;

endmodule

// File: tb/tb_rom_dma_engine.sv
// Scoreboard bench: a ROM model answers load_rom, expected writes are queued at
// each load and checked when dst_write fires.
module tb_rom_dma_engine;
    import rom_dma_engine_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, write = 1'b0;
    logic [1:0]  wr_mode = 2'd0;
    logic [15:0] ctrl_data = 16'd0;
    logic [23:0] src_addr;
    logic        load_rom;
    logic [15:0] src_data = 16'd0;
    logic        ready = 1'b0;
    logic [15:0] dst_addr;
    logic        dst_write;
    logic [15:0] dst_data;
    logic        proc_en, busy, error;

    rom_dma_engine #(.SRC_W(24), .DST_W(16), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .en(en), .write(write), .wr_mode(wr_mode),
        .ctrl_data(ctrl_data), .src_addr(src_addr), .load_rom(load_rom),
        .src_data(src_data), .ready(ready), .dst_addr(dst_addr),
        .dst_write(dst_write), .dst_data(dst_data), .proc_en(proc_en),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         e;
    int          checks = 0;
    int          errors = 0;
    int          load_cnt = 0;
    int          wr_cnt = 0;
    logic [23:0] exp_src = 24'd0;
    logic [15:0] exp_dst = 16'd0;

    bit          rom_never = 1'b0;
    bit          stale_mode = 1'b0;
    int          rom_delay = 4;
    int          cnt = 0;
    bit          pend = 1'b0;
    logic [23:0] rom_addr = 24'd0;

    // Monitor/scoreboard then ROM model, all at the falling edge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_src = 24'd0;
            exp_dst = 16'd0;
            pend    = 1'b0;
            ready   = 1'b0;
        end else begin
            if (load_rom) begin
                load_cnt++;
                checks++;
                if (src_addr !== exp_src) begin
                    errors++;
                    $display("FAIL load_addr got %h exp %h", src_addr, exp_src);
                end
                sb.push_back('{exp_dst, 16'(16'hA000 + exp_src[15:0])});
            end
            if (dst_write) begin
                wr_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr %h data %h", dst_addr, dst_data);
                end else begin
                    e = sb.pop_front();
                    if (dst_addr !== e.addr || dst_data !== e.data) begin
                        errors++;
                        $display("FAIL write got addr %h data %h exp addr %h data %h",
                                 dst_addr, dst_data, e.addr, e.data);
                    end
                    exp_src++;
                    exp_dst++;
                end
            end
            // ROM model
            if (load_rom) begin
                rom_addr = src_addr;
                cnt      = rom_delay;
                pend     = 1'b1;
            end else if (pend && cnt > 0) begin
                cnt--;
            end
            if (rom_never) begin
                ready = 1'b0;
            end else if (pend && cnt == 0) begin
                ready    = 1'b1;
                src_data = 16'(16'hA000 + rom_addr[15:0]);
            end else if (stale_mode && pend && cnt >= rom_delay - 1) begin
                ready    = 1'b1;
                src_data = 16'hDEAD;
            end else begin
                ready = 1'b0;
            end
        end
    end

    task automatic prog(input logic [1:0] m, input logic [15:0] d);
        @(negedge clk);
        en = 1'b1; write = 1'b1; wr_mode = m; ctrl_data = d;
        case (m)
            MODE_SRC_LO: exp_src[15:0]  = d;
            MODE_SRC_HI: exp_src[23:16] = d[7:0];
            MODE_DST:    exp_dst        = d;
            default: ;
        endcase
        @(negedge clk);
        en = 1'b0; write = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int cycles, output bit proc_bad,
                             output bit last_wr);
        bit prev_wr;
        cycles = 0; proc_bad = 1'b0; prev_wr = 1'b0;
        while (busy === 1'b1 && cycles < bound) begin
            if (proc_en !== 1'b0) proc_bad = 1'b1;
            prev_wr = dst_write;
            @(negedge clk);
            cycles++;
        end
        last_wr = prev_wr;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({load_rom, dst_write, proc_en, busy, error} !== 5'b00100 ||
            src_addr !== 24'd0 || dst_addr !== 16'd0 || dst_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got ld=%b wr=%b pe=%b bs=%b er=%b src=%h dst=%h data=%h",
                     load_rom, dst_write, proc_en, busy, error, src_addr, dst_addr, dst_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int l0, w0, cyc; bit pbad, lw;
        l0 = load_cnt; w0 = wr_cnt;
        prog(MODE_SRC_LO, 16'h0100); prog(MODE_SRC_HI, 16'h0000);
        prog(MODE_DST, 16'h4000);    prog(MODE_LEN_GO, 16'd3);
        wait_idle(200, cyc, pbad, lw);
        checks++;
        if (cyc >= 200) begin errors++; $display("FAIL basic_done timed out after %0d", cyc); end
        checks++;
        if (pbad || !lw || proc_en !== 1'b1) begin
            errors++;
            $display("FAIL basic_proc_en got low_bad=%b last_wr_before=%b proc_en=%b exp 0 1 1",
                     pbad, lw, proc_en);
        end
        checks++;
        if (load_cnt - l0 != 3 || wr_cnt - w0 != 3 || sb.size() != 0) begin
            errors++;
            $display("FAIL basic_counts got loads %0d writes %0d pending %0d exp 3 3 0",
                     load_cnt - l0, wr_cnt - w0, sb.size());
        end
        checks++;
        if (src_addr !== 24'h000103 || dst_addr !== 16'h4003 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_next_addr got src %h dst %h err %b exp 000103 4003 0",
                     src_addr, dst_addr, error);
        end
    endtask

    task automatic test_len_zero();
        int l0; bit bad;
        l0 = load_cnt; bad = 1'b0;
        prog(MODE_LEN_GO, 16'd0);
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0 || proc_en !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad || load_cnt != l0) begin
            errors++;
            $display("FAIL len_zero got busy_seen=%b loads %0d exp 0 0", bad, load_cnt - l0);
        end
    endtask

    task automatic test_timeout();
        int w0, cyc; bit pbad, lw;
        w0 = wr_cnt;
        rom_never = 1'b1;
        prog(MODE_DST, 16'h0020);
        prog(MODE_LEN_GO, 16'd1);
        wait_idle(400, cyc, pbad, lw);
        checks++;
        if (cyc < 256 || cyc > 258) begin
            errors++;
            $display("FAIL timeout_cycles got %0d exp 256..258", cyc);
        end
        checks++;
        if (error !== 1'b1 || proc_en !== 1'b1 || wr_cnt != w0 || sb.size() != 1) begin
            errors++;
            $display("FAIL timeout_abort got err %b pe %b writes %0d pending %0d exp 1 1 0 1",
                     error, proc_en, wr_cnt - w0, sb.size());
        end
        sb.delete();
        rom_never = 1'b0;
        prog(MODE_LEN_GO, 16'd1);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear got err %b busy %b exp 0 1", error, busy);
        end
        wait_idle(200, cyc, pbad, lw);
        checks++;
        if (cyc >= 200 || wr_cnt - w0 != 1 || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_retry got cyc %0d writes %0d err %b exp <200 1 0",
                     cyc, wr_cnt - w0, error);
        end
    endtask

    task automatic test_wrap();
        int l0, w0, cyc; bit pbad, lw;
        l0 = load_cnt; w0 = wr_cnt;
        prog(MODE_SRC_LO, 16'hFFFF); prog(MODE_SRC_HI, 16'h00FF);
        prog(MODE_DST, 16'hFFFF);    prog(MODE_LEN_GO, 16'd2);
        wait_idle(200, cyc, pbad, lw);
        checks++;
        if (cyc >= 200 || load_cnt - l0 != 2 || wr_cnt - w0 != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_counts got cyc %0d loads %0d writes %0d exp <200 2 2",
                     cyc, load_cnt - l0, wr_cnt - w0);
        end
        checks++;
        if (src_addr !== 24'h000001 || dst_addr !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_next_addr got src %h dst %h exp 000001 0001", src_addr, dst_addr);
        end
    endtask

    task automatic test_stale_ready();
        int w0, cyc; bit pbad, lw;
        w0 = wr_cnt;
        stale_mode = 1'b1;
        prog(MODE_SRC_LO, 16'h0200); prog(MODE_SRC_HI, 16'h0000);
        prog(MODE_DST, 16'h0010);    prog(MODE_LEN_GO, 16'd2);
        wait_idle(200, cyc, pbad, lw);
        stale_mode = 1'b0;
        checks++;
        if (cyc >= 200 || wr_cnt - w0 != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL stale_counts got cyc %0d writes %0d pending %0d exp <200 2 0",
                     cyc, wr_cnt - w0, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int l0, w0, w1, n;
        l0 = load_cnt; w0 = wr_cnt;
        prog(MODE_SRC_LO, 16'h0300); prog(MODE_DST, 16'h0050); prog(MODE_LEN_GO, 16'd5);
        n = 0;
        while (load_cnt - l0 < 2 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL rstmid_second_load timed out"); end
        @(negedge clk);  // guard cycle of word 2
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({load_rom, dst_write, proc_en, busy, error} !== 5'b00100 ||
            src_addr !== 24'd0 || dst_addr !== 16'd0 || dst_data !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_async got ld=%b wr=%b pe=%b bs=%b er=%b src=%h dst=%h",
                     load_rom, dst_write, proc_en, busy, error, src_addr, dst_addr);
        end
        w1 = wr_cnt;
        checks++;
        if (w1 - w0 != 1) begin
            errors++;
            $display("FAIL rstmid_writes_before got %0d exp 1", w1 - w0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (wr_cnt != w1 || busy !== 1'b0 || proc_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after got writes %0d busy %b pe %b exp 0 0 1",
                     wr_cnt - w1, busy, proc_en);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_timeout();
        test_wrap();
        test_stale_ready();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
